// File: rtl/rvv_pkg.sv
// Shared definitions for the vector register-group write-back path.
package rvv_pkg;

  localparam int VLEN   = 64;
  localparam int NREG   = 32;
  localparam int NBYTES = VLEN / 8;

  // vtype field positions
  localparam int VSEW_MSB  = 5;
  localparam int VSEW_LSB  = 3;
  localparam int VLMUL_MSB = 2;
  localparam int VLMUL_LSB = 0;

  // vsew encodings
  localparam logic [2:0] SEW8  = 3'd0;
  localparam logic [2:0] SEW16 = 3'd1;
  localparam logic [2:0] SEW32 = 3'd2;
  localparam logic [2:0] SEW64 = 3'd3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } wb_state_e;

  // Elements per group: (VLEN / SEW) * LMUL, at most 64 for VLEN=64.
  function automatic logic [7:0] vlmax_f(input logic [1:0] vsew, input logic [1:0] vlmul);
    logic [7:0] epr;
    epr = 8'(NBYTES) >> vsew;
    return epr << vlmul;
  endfunction

endpackage

// File: rtl/vl_tail_mask_gen.sv
// Byte-enable mask for one register of a group: body bytes set, tail bytes clear.
module vl_tail_mask_gen
  import rvv_pkg::*;
(
  input  logic [7:0]        vl_eff,
  input  logic [2:0]        idx,
  input  logic [1:0]        vsew,
  output logic [NBYTES-1:0] byte_mask
);

  logic [8:0] epr;
  logic [8:0] base;
  logic [8:0] rem;
  logic [8:0] act;
  logic [8:0] nb;

  // Active elements in this register = clamp(vl_eff - idx*epr, 0, epr), then scaled to bytes.
  always_comb begin
    epr  = 9'(NBYTES) >> vsew;
    base = 9'(idx) * epr;
    rem  = ({1'b0, vl_eff} > base) ? ({1'b0, vl_eff} - base) : 9'd0;
    act  = (rem > epr) ? epr : rem;
    nb   = act << vsew;
    byte_mask = '0;
    for (int b = 0; b < NBYTES; b++) begin
      byte_mask[b] = (9'(b) < nb);
    end
  end

endmodule

// File: rtl/vrf_group_writeback.sv
// Tail-undisturbed write-back of one LMUL register group into the VRF.
//
//  state  | meaning
//  IDLE   | waiting for start; rejects illegal configs, handles vl_eff==0 inline
//  ACTIVE | accepting one lane result per group register, writing merged data
module vrf_group_writeback
  import rvv_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [4:0]  vd_base,
  input  logic [7:0]  vl,
  input  logic [6:0]  vtype,
  output logic        busy,
  output logic        illegal,
  input  logic        res_valid,
  input  logic [63:0] res_data,
  output logic        res_ready,
  output logic [4:0]  vrf_rd_addr,
  input  logic [63:0] vrf_rd_data,
  output logic        vrf_we,
  output logic [4:0]  vrf_wa,
  output logic [63:0] vrf_wd,
  output logic        done
);

  wb_state_e   state_q, state_d;
  logic [4:0]  vd_base_q, vd_base_d;
  logic [1:0]  vsew_q, vsew_d;
  logic [1:0]  vlmul_q, vlmul_d;
  logic [7:0]  vl_eff_q, vl_eff_d;
  logic [2:0]  idx_q, idx_d;
  logic        illegal_q, illegal_d;
  logic        vrf_we_q, vrf_we_d;
  logic [4:0]  vrf_wa_q, vrf_wa_d;
  logic [63:0] vrf_wd_q, vrf_wd_d;
  logic        done_q, done_d;

  logic [2:0]        vsew_in;
  logic [2:0]        vlmul_in;
  logic [4:0]        align_mask;
  logic              start_legal;
  logic [7:0]        vlmax_in;
  logic [7:0]        vl_eff_in;
  logic [3:0]        nregs;
  logic              last_reg;
  logic              handshake;
  logic [4:0]        addr_cur;
  logic [NBYTES-1:0] byte_mask;
  logic [63:0]       merged;

  // vtype[6] is reserved and deliberately ignored.
  logic unused_vtype;
  assign unused_vtype = vtype[6];

  // Start decode: legality, alignment and clamped vector length.
  always_comb begin
    vsew_in     = vtype[VSEW_MSB:VSEW_LSB];
    vlmul_in    = vtype[VLMUL_MSB:VLMUL_LSB];
    align_mask  = (5'd1 << vlmul_in[1:0]) - 5'd1;
    start_legal = !vsew_in[2] && !vlmul_in[2] && ((vd_base & align_mask) == 5'd0);
    vlmax_in    = vlmax_f(vsew_in[1:0], vlmul_in[1:0]);
    vl_eff_in   = (vl < vlmax_in) ? vl : vlmax_in;
  end

  vl_tail_mask_gen u_mask (
    .vl_eff    (vl_eff_q),
    .idx       (idx_q),
    .vsew      (vsew_q),
    .byte_mask (byte_mask)
  );

  // Per-register address, handshake and byte merge against the old vd.
  always_comb begin
    nregs     = 4'd1 << vlmul_q;
    last_reg  = ({1'b0, idx_q} == (nregs - 4'd1));
    handshake = res_valid && (state_q == ACTIVE);
    addr_cur  = vd_base_q + 5'(idx_q);
    merged    = vrf_rd_data;
    for (int b = 0; b < NBYTES; b++) begin
      if (byte_mask[b]) merged[b*8 +: 8] = res_data[b*8 +: 8];
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    vd_base_d = vd_base_q;
    vsew_d    = vsew_q;
    vlmul_d   = vlmul_q;
    vl_eff_d  = vl_eff_q;
    idx_d     = idx_q;
    illegal_d = 1'b0;
    vrf_we_d  = 1'b0;
    vrf_wa_d  = vrf_wa_q;
    vrf_wd_d  = vrf_wd_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_legal) begin
            vd_base_d = vd_base;
            vsew_d    = vsew_in[1:0];
            vlmul_d   = vlmul_in[1:0];
            vl_eff_d  = vl_eff_in;
            idx_d     = 3'd0;
            if (vl_eff_in == 8'd0) done_d = 1'b1;
            else                   state_d = ACTIVE;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ACTIVE: begin
        if (handshake) begin
          vrf_we_d = 1'b1;
          vrf_wa_d = addr_cur;
          vrf_wd_d = merged;
          if (last_reg) begin
            done_d  = 1'b1;
            idx_d   = 3'd0;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any in-flight group and pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      vd_base_q <= '0;
      vsew_q    <= '0;
      vlmul_q   <= '0;
      vl_eff_q  <= '0;
      idx_q     <= '0;
      illegal_q <= 1'b0;
      vrf_we_q  <= 1'b0;
      vrf_wa_q  <= '0;
      vrf_wd_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vd_base_q <= vd_base_d;
      vsew_q    <= vsew_d;
      vlmul_q   <= vlmul_d;
      vl_eff_q  <= vl_eff_d;
      idx_q     <= idx_d;
      illegal_q <= illegal_d;
      vrf_we_q  <= vrf_we_d;
      vrf_wa_q  <= vrf_wa_d;
      vrf_wd_q  <= vrf_wd_d;
      done_q    <= done_d;
    end
  end

  assign busy        = (state_q == ACTIVE);
  assign res_ready   = (state_q == ACTIVE);
  assign vrf_rd_addr = (state_q == ACTIVE) ? addr_cur : 5'd0;
  assign illegal     = illegal_q;
  assign vrf_we      = vrf_we_q;
  assign vrf_wa      = vrf_wa_q;
  assign vrf_wd      = vrf_wd_q;
  assign done        = done_q;

endmodule
